// File: rtl/display_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : display_scan_ctrl
// Purpose  : 3-digit multiplexed 7-segment scanner with double-buffered BCD load.
//            Optional leading-zero blanking: DISPLAY_SCAN_LEAD_ZERO_BLANK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module display_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load_valid,
  input  logic [11:0] load_data,
  output logic        load_ready,
  output logic [2:0]  transistor,
  output logic [6:0]  d7sp,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] C_SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_idx;
  logic [1:0]    w_idx_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [11:0]   r_pending;
  logic [11:0]   r_active;
  logic          r_pending_full;
  logic          w_wrap;
  logic [3:0]    w_digit;
  logic          w_dark;
  logic          w_drive;
  logic [2:0]    w_tr_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_fd_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0111111;
      4'd1:    seg_decode = 7'b0000110;
      4'd2:    seg_decode = 7'b1011011;
      4'd3:    seg_decode = 7'b1001111;
      4'd4:    seg_decode = 7'b1100110;
      4'd5:    seg_decode = 7'b1101101;
      4'd6:    seg_decode = 7'b1111101;
      4'd7:    seg_decode = 7'b0000111;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1101111;
      default: seg_decode = 7'b1000000;
    endcase
  endfunction

  assign load_ready = !r_pending_full;
  // Last DRIVE cycle of digit 2; the frame buffer swap happens at its closing edge.
  assign w_wrap = (r_state == S_DRIVE) && (r_idx == 2'd2) && (r_cnt == C_SLOT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + CW'(1);
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 2'd0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_BLANK;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = '0;
        end
        S_BLANK: begin
          if (r_cnt == C_BLANK_LAST) w_state_nxt = S_DRIVE;
        end
        S_DRIVE: begin
          if (r_cnt == C_SLOT_LAST) begin
            w_state_nxt = S_BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    case (w_idx_nxt)
      2'd0:    w_digit = r_active[3:0];
      2'd1:    w_digit = r_active[7:4];
      default: w_digit = r_active[11:8];
    endcase
  end

`ifdef DISPLAY_SCAN_LEAD_ZERO_BLANK_EN
  assign w_dark = ((w_idx_nxt == 2'd2) && (r_active[11:8] == 4'd0)) ||
                  ((w_idx_nxt == 2'd1) && (r_active[11:4] == 8'd0));
`else
  assign w_dark = 1'b0;
`endif

  // Outputs are registered from next-state values so they line up with the state.
  assign w_drive   = (w_state_nxt == S_DRIVE) && !w_dark;
  assign w_tr_nxt  = w_drive ? (3'b001 << w_idx_nxt) : 3'b000;
  assign w_seg_nxt = w_drive ? seg_decode(w_digit) : 7'b0000000;
  assign w_fd_nxt  = (w_state_nxt == S_DRIVE) && (w_idx_nxt == 2'd2) &&
                     (w_cnt_nxt == C_SLOT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_cnt      <= '0;
      transistor <= 3'b000;
      d7sp       <= 7'b0000000;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      transistor <= w_tr_nxt;
      d7sp       <= w_seg_nxt;
      frame_done <= w_fd_nxt;
    end
  end

  // Swap and accept are mutually exclusive: a swap needs pending_full, an accept needs it clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending      <= 12'h000;
      r_active       <= 12'h000;
      r_pending_full <= 1'b0;
    end else begin
      if (w_wrap && r_pending_full) begin
        r_active       <= r_pending;
        r_pending_full <= 1'b0;
      end
      if (load_valid && !r_pending_full) begin
        r_pending      <= load_data;
        r_pending_full <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_display_scan_ctrl
// Purpose  : Cycle-stamped scoreboard bench for display_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_display_scan_ctrl;

`ifdef DISPLAY_SCAN_LEAD_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load_valid;
  logic [11:0] load_data;
  logic        load_ready;
  logic [2:0]  transistor;
  logic [6:0]  d7sp;
  logic        frame_done;

  display_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .transistor (transistor),
    .d7sp       (d7sp),
    .frame_done (frame_done)
  );

  typedef struct {
    int         cyc;
    bit         chk_out;
    bit         chk_lr;
    logic [2:0] tr;
    logic [6:0] seg;
    logic       fd;
    logic       lr;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        vectors++;
        if ((sb[i].chk_out && (transistor !== sb[i].tr || d7sp !== sb[i].seg ||
                               frame_done !== sb[i].fd)) ||
            (sb[i].chk_lr && load_ready !== sb[i].lr)) begin
          miscompares++;
          $display("FAIL %s @cyc %0d: got tr=%b seg=%b fd=%b lr=%b, want tr=%b seg=%b fd=%b lr=%b",
                   sb[i].tag, cyc, transistor, d7sp, frame_done, load_ready,
                   sb[i].tr, sb[i].seg, sb[i].fd, sb[i].lr);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push_out(input int c, input logic [2:0] tr, input logic [6:0] seg,
                          input logic fd, input string tag);
    exp_t e;
    e.cyc = c; e.chk_out = 1'b1; e.chk_lr = 1'b0;
    e.tr = tr; e.seg = seg; e.fd = fd; e.lr = 1'b0; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_lr(input int c, input logic lr, input string tag);
    exp_t e;
    e.cyc = c; e.chk_out = 1'b0; e.chk_lr = 1'b1;
    e.tr = 3'b000; e.seg = 7'b0; e.fd = 1'b0; e.lr = lr; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_frame(input int base, input logic [11:0] val,
                            input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input int ncyc, input string tag);
    for (int k = 0; k < ncyc; k++) begin
      int         slot;
      int         pos;
      bit         dark;
      logic [2:0] tr;
      logic [6:0] seg;
      slot = k / 8;
      pos  = k % 8;
      dark = LZ && ((slot == 2 && val[11:8] == 4'd0) || (slot == 1 && val[11:4] == 8'd0));
      if (pos < 2 || dark) begin
        tr  = 3'b000;
        seg = 7'b0000000;
      end else begin
        tr  = (slot == 0) ? 3'b001 : (slot == 1) ? 3'b010 : 3'b100;
        seg = (slot == 0) ? s0 : (slot == 1) ? s1 : s2;
      end
      push_out(base + k, tr, seg, (k == 23), tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = 12'h000;
    for (int c = 1; c <= 3; c++) begin
      push_out(c, 3'b000, 7'b0, 1'b0, "reset_out");
      push_lr(c, 1'b1, "reset_lr");
    end
    wait_until(3);
    n = cyc;
    vectors++;
    if (load_ready !== 1'b1 || transistor !== 3'b000 || d7sp !== 7'b0000000 ||
        frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_reset @cyc %0d: lr=%b tr=%b seg=%b fd=%b",
               cyc, load_ready, transistor, d7sp, frame_done);
    end

    rst = 1'b0; enable = 1'b1; load_valid = 1'b1; load_data = 12'h123;
    push_lr(n + 1, 1'b0, "lr_after_load");
    push_frame(n + 1,  12'h000, 7'b0111111, 7'b0111111, 7'b0111111, 24, "frame_000");
    push_frame(n + 25, 12'h123, 7'b1001111, 7'b1011011, 7'b0000110, 24, "frame_123");
    wait_until(n + 1);
    vectors++;
    if (load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_load_accept @cyc %0d: lr=%b", cyc, load_ready);
    end
    load_valid = 1'b0;

    wait_until(n + 25);
    load_valid = 1'b1; load_data = 12'h456;
    push_lr(n + 25, 1'b1, "lr_free_after_wrap");
    wait_until(n + 26);
    load_data = 12'h789;
    push_lr(n + 26, 1'b0, "lr_stall_start");
    push_lr(n + 48, 1'b0, "lr_stall_fd_cycle");
    push_lr(n + 49, 1'b1, "lr_free_after_fd");
    push_lr(n + 50, 1'b0, "lr_789_taken");
    push_frame(n + 49, 12'h456, 7'b1111101, 7'b1101101, 7'b1100110, 24, "frame_456");
    push_frame(n + 73, 12'h789, 7'b1101111, 7'b1111111, 7'b0000111, 24, "frame_789");
    wait_until(n + 50);
    load_valid = 1'b0;

    wait_until(n + 73);
    load_valid = 1'b1; load_data = 12'h0A5;
    push_lr(n + 73, 1'b1, "lr_before_0a5");
    push_frame(n + 97, 12'h0A5, 7'b1101101, 7'b1000000, 7'b0111111, 24, "frame_0a5");
    wait_until(n + 74);
    load_valid = 1'b0;

    wait_until(n + 97);
    load_valid = 1'b1; load_data = 12'h007;
    push_frame(n + 121, 12'h007, 7'b0000111, 7'b0111111, 7'b0111111, 24, "frame_007");
    wait_until(n + 98);
    load_valid = 1'b0;

    wait_until(n + 121);
    load_valid = 1'b1; load_data = 12'h321;
    push_frame(n + 145, 12'h321, 7'b0000110, 7'b1011011, 7'b1001111, 13, "frame_321_cut");
    push_out(n + 158, 3'b000, 7'b0, 1'b0, "idle_after_disable");
    push_out(n + 159, 3'b000, 7'b0, 1'b0, "idle_hold");
    push_frame(n + 160, 12'h321, 7'b0000110, 7'b1011011, 7'b1001111, 11, "frame_321_restart");
    wait_until(n + 122);
    load_valid = 1'b0;

    wait_until(n + 157);
    enable = 1'b0;
    wait_until(n + 159);
    enable = 1'b1;

    wait_until(n + 160);
    load_valid = 1'b1; load_data = 12'h654;
    push_lr(n + 160, 1'b1, "lr_before_654");
    push_lr(n + 161, 1'b0, "lr_654_pending");
    wait_until(n + 161);
    load_valid = 1'b0;

    wait_until(n + 170);
    rst = 1'b1;
    push_out(n + 171, 3'b000, 7'b0, 1'b0, "midframe_reset_out");
    push_lr(n + 171, 1'b1, "midframe_reset_lr");
    push_lr(n + 172, 1'b1, "lr_after_reset");
    push_frame(n + 172, 12'h000, 7'b0111111, 7'b0111111, 7'b0111111, 24, "frame_after_reset");
    push_frame(n + 196, 12'h000, 7'b0111111, 7'b0111111, 7'b0111111, 4, "pending_discarded");
    wait_until(n + 171);
    rst = 1'b0;

    wait_until(n + 202);
    foreach (sb[k]) begin
      vectors++;
      miscompares++;
      $display("FAIL %s @cyc %0d: never checked", sb[k].tag, sb[k].cyc);
    end
    if (vectors == 0) begin
      miscompares++;
      $display("FAIL no vectors were checked");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares == 0)
      $display("PASS");
    else
      $display("FAIL");
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal only when SCAN_DIV > BLANK_CYC.
REQ-002 SHALL provide parameter BLANK_CYC, default 8, dark cycles at the start of each slot; legal only when BLANK_CYC >= 1.
REQ-003 SHALL provide port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL provide port enable  input  1  scan enable.
REQ-006 SHALL provide port load_valid  input  1  new display value offered.
REQ-007 SHALL provide port load_data  input  12  three BCD digits: [3:0] digit0 (LSD), [7:4] digit1, [11:8] digit2.
REQ-008 SHALL provide port load_ready  output  1  pending buffer empty, load accepted.
REQ-009 SHALL provide port transistor  output  3  one-hot, active-high digit select; bit n drives digit n.
REQ-010 SHALL provide port d7sp  output  7  active-high segments; bit0=a ... bit6=g.
REQ-011 SHALL provide port frame_done  output  1  one-cycle pulse at the end of each 3-digit frame.

Function
REQ-012 SHALL keep two 12-bit registers, pending and active, plus a pending_full flag; load_ready = !pending_full.
REQ-013 SHALL capture load_data into pending and set pending_full on a cycle where load_valid && load_ready; load_ready goes low the next cycle.
REQ-014 SHALL set load_data flow control as stall-only: load_valid while load_ready=0 is ignored, with no loss of pending.
REQ-015 SHALL run an FSM with states IDLE, BLANK and DRIVE, plus a 2-bit digit index (0..2) and a slot cycle counter.
REQ-016 SHALL behave as follows in IDLE (enable=0): transistor=000, d7sp=0000000, index=0, counter=0; pending and active are held.
REQ-017 SHALL move from IDLE to BLANK on the cycle after enable is sampled 1.
REQ-018 SHALL hold BLANK for exactly BLANK_CYC cycles with transistor=000 and d7sp=0000000, then enter DRIVE.
REQ-019 SHALL hold DRIVE for exactly SCAN_DIV-BLANK_CYC cycles with transistor one-hot[index] and d7sp=decode(active digit[index]), then enter BLANK with index+1.
REQ-020 SHALL wrap the index from 2 to 0 at the end of the digit-2 DRIVE; frame period = 3*SCAN_DIV cycles.
REQ-021 SHALL, in that wrap cycle, pulse frame_done=1 and, if pending_full was set before the cycle, copy pending to active and clear pending_full.
REQ-022 SHALL resolve a simultaneous accepted load and wrap as follows: the load is captured into pending; active keeps its old value until the next wrap.
REQ-023 SHALL decode digits 0-9 to standard patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111 (bit6..bit0).
REQ-024 SHALL decode BCD codes 10-15 to dash 1000000.
REQ-025 SHALL, when enable falls in any state, enter IDLE on the next cycle; re-enable restarts at BLANK, index 0.
REQ-026 SHALL register all outputs and never assert more than one transistor bit at once.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, force IDLE, index=0, counter=0, active=000h, pending=000h, pending_full=0.
REQ-028 SHALL, on rst=1, force transistor=000, d7sp=0000000, frame_done=0 and load_ready=1 from the following cycle.
REQ-029 SHALL give reset priority over enable and load_valid; reset mid-frame discards pending data.

Configuration
REQ-030 SHALL, with macro DISPLAY_SCAN_LEAD_ZERO_BLANK_EN defined, suppress leading zeros.
REQ-031 SHALL, when leading-zero suppression is on, darken digit2 if it is 0.
REQ-032 SHALL, when leading-zero suppression is on, darken digit1 if both digit2 and digit1 are 0.
REQ-033 SHALL keep digit0 always displayed.
REQ-034 SHALL drive a darkened slot with transistor=000 and d7sp=0000000 for its full SCAN_DIV cycles; slot timing is unchanged.
REQ-035 SHALL, with DISPLAY_SCAN_LEAD_ZERO_BLANK_EN undefined, display all three digits unconditionally.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-036 SHALL cover: reset, enable=1, load 123h -> after first frame_done, slots show 2 cycles 000/0000000 then 6 cycles 001/1001111, then 010/1011011, then 100/0000110; frame_done every 24 cycles.
REQ-037 SHALL cover: load 456h then immediately offer 789h -> load_ready=0, 789h stalled until the frame_done cycle; accepted next cycle; displayed one frame later.
REQ-038 SHALL cover: load 0A5h -> digit1 slot shows d7sp=1000000.
REQ-039 SHALL cover: enable dropped at the 3rd DRIVE cycle of digit1 -> next cycle 000/0000000; re-enable -> BLANK at digit0 after one cycle.
REQ-040 SHALL cover: rst asserted mid-frame with pending_full=1 -> next cycle load_ready=1, outputs 0, and active=000h on resume.
REQ-041 SHALL cover: with DISPLAY_SCAN_LEAD_ZERO_BLANK_EN defined, load 007h -> digit2 and digit1 slots fully dark; digit0 slot shows 001/0000111.
